// File: rtl/hqm_aw_rf_pg_seq.sv
// Power-gate sequencer for one power-gated RF/SRAM wrapper.
// Walks pwr_enable_b, isolation and ip_reset_b through an ordered power-up
// and power-down. It waits on the chain acknowledge and keeps functional
// access off until the memory is powered, de-isolated and out of reset.
module hqm_aw_rf_pg_seq #(
  parameter int unsigned ISO_SETTLE  = 4,
  parameter int unsigned RST_HOLD    = 8,
  parameter int unsigned PWR_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic pwr_req,
  input  logic mem_active,
  input  logic pwr_enable_b_ack,
  input  logic err_clr,
  output logic pwr_enable_b,
  output logic pgcb_isol_en,
  output logic ip_reset_b,
  output logic access_en,
  output logic pwr_on,
  output logic busy,
  output logic timeout_err
);

  localparam int unsigned MAX_AB = (ISO_SETTLE > RST_HOLD) ? ISO_SETTLE : RST_HOLD;
  localparam int unsigned MAX_T  = (MAX_AB > PWR_TIMEOUT) ? MAX_AB : PWR_TIMEOUT;
  localparam int unsigned CNT_W  = $clog2(MAX_T + 1);

  // Last counter value spent in a timed state; the exit happens on the following edge.
  localparam logic [CNT_W-1:0] ISO_LAST = CNT_W'(ISO_SETTLE - 1);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_HOLD - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(PWR_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_UP_WAIT = 3'd1,
    ST_ISO_REL = 3'd2,
    ST_RST_REL = 3'd3,
    ST_ON      = 3'd4,
    ST_QUIESCE = 3'd5,
    ST_ISO_SET = 3'd6,
    ST_DN_WAIT = 3'd7
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pwr_enable_b_q, pwr_enable_b_d;
  logic             isol_q, isol_d;
  logic             ip_reset_b_q, ip_reset_b_d;
  logic             access_en_q, access_en_d;
  logic             pwr_on_q, pwr_on_d;
  logic             busy_q, busy_d;
  logic             timeout_err_q, timeout_err_d;
  logic             set_err;

  // Next state, counter, sticky error and next-state-decoded outputs.
  always_comb begin
    state_d        = state_q;
    set_err        = 1'b0;
    pwr_enable_b_d = 1'b1;
    isol_d         = 1'b1;
    ip_reset_b_d   = 1'b0;
    access_en_d    = 1'b0;
    pwr_on_d       = 1'b0;
    busy_d         = 1'b1;

    case (state_q)
      ST_OFF:     if (pwr_req) state_d = ST_UP_WAIT;
      ST_UP_WAIT: begin
        if (!pwr_enable_b_ack) begin
          state_d = ST_ISO_REL;
        end else if (cnt_q == TO_LAST) begin
          set_err = 1'b1;
          state_d = ST_DN_WAIT;
        end
      end
      ST_ISO_REL: if (cnt_q == ISO_LAST) state_d = ST_RST_REL;
      ST_RST_REL: if (cnt_q == RST_LAST) state_d = ST_ON;
      ST_ON:      if (!pwr_req) state_d = ST_QUIESCE;
      ST_QUIESCE: if (!mem_active) state_d = ST_ISO_SET;
      ST_ISO_SET: if (cnt_q == ISO_LAST) state_d = ST_DN_WAIT;
      ST_DN_WAIT: begin
        if (pwr_enable_b_ack) begin
          state_d = ST_OFF;
        end else if (cnt_q == TO_LAST) begin
          set_err = 1'b1;
          state_d = ST_OFF;
        end
      end
      default:    state_d = ST_OFF;
    endcase

    // Counter restarts on every state entry and saturates otherwise.
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_SAT) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // A new timeout wins over a simultaneous clear.
    timeout_err_d = set_err | (timeout_err_q & ~err_clr);

    // Outputs follow the state being entered so they change on the entry edge.
    case (state_d)
      ST_OFF:     busy_d = 1'b0;
      ST_UP_WAIT: pwr_enable_b_d = 1'b0;
      ST_ISO_REL: begin
        pwr_enable_b_d = 1'b0;
        isol_d         = 1'b0;
      end
      ST_RST_REL: begin
        pwr_enable_b_d = 1'b0;
        isol_d         = 1'b0;
        ip_reset_b_d   = 1'b1;
      end
      ST_ON: begin
        pwr_enable_b_d = 1'b0;
        isol_d         = 1'b0;
        ip_reset_b_d   = 1'b1;
        access_en_d    = 1'b1;
        pwr_on_d       = 1'b1;
        busy_d         = 1'b0;
      end
      ST_QUIESCE: begin
        pwr_enable_b_d = 1'b0;
        isol_d         = 1'b0;
        ip_reset_b_d   = 1'b1;
      end
      ST_ISO_SET: pwr_enable_b_d = 1'b0;
      default:    ;
    endcase
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_OFF;
      cnt_q          <= '0;
      pwr_enable_b_q <= 1'b1;
      isol_q         <= 1'b1;
      ip_reset_b_q   <= 1'b0;
      access_en_q    <= 1'b0;
      pwr_on_q       <= 1'b0;
      busy_q         <= 1'b0;
      timeout_err_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      pwr_enable_b_q <= pwr_enable_b_d;
      isol_q         <= isol_d;
      ip_reset_b_q   <= ip_reset_b_d;
      access_en_q    <= access_en_d;
      pwr_on_q       <= pwr_on_d;
      busy_q         <= busy_d;
      timeout_err_q  <= timeout_err_d;
    end
  end

  assign pwr_enable_b = pwr_enable_b_q;
  assign pgcb_isol_en = isol_q;
  assign ip_reset_b   = ip_reset_b_q;
  assign access_en    = access_en_q;
  assign pwr_on       = pwr_on_q;
  assign busy         = busy_q;
  assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_hqm_aw_rf_pg_seq.sv
// Directed bench for the power-gate sequencer with a delayed chain-ack model.
module tb_hqm_aw_rf_pg_seq;

  logic clk;
  logic rst;
  logic pwr_req;
  logic mem_active;
  logic pwr_enable_b_ack;
  logic err_clr;
  logic pwr_enable_b;
  logic pgcb_isol_en;
  logic ip_reset_b;
  logic access_en;
  logic pwr_on;
  logic busy;
  logic timeout_err;

  int n_vec;
  int n_err;

  logic [2:0] ack_sh;
  logic       ack_stuck;
  logic       iso_seen;
  logic [6:0] obs;

  // Output encodings {pwr_enable_b, isol, ip_reset_b, access_en, pwr_on, busy, timeout_err}
  localparam logic [6:0] O_OFF     = 7'b1100000;
  localparam logic [6:0] O_UP_WAIT = 7'b0100010;
  localparam logic [6:0] O_ISO_REL = 7'b0000010;
  localparam logic [6:0] O_RST_REL = 7'b0010010;
  localparam logic [6:0] O_ON      = 7'b0011100;
  localparam logic [6:0] O_QUIESCE = 7'b0010010;
  localparam logic [6:0] O_ISO_SET = 7'b0100010;
  localparam logic [6:0] O_DN_WAIT = 7'b1100010;

  hqm_aw_rf_pg_seq dut (
    .clk              (clk),
    .rst              (rst),
    .pwr_req          (pwr_req),
    .mem_active       (mem_active),
    .pwr_enable_b_ack (pwr_enable_b_ack),
    .err_clr          (err_clr),
    .pwr_enable_b     (pwr_enable_b),
    .pgcb_isol_en     (pgcb_isol_en),
    .ip_reset_b       (ip_reset_b),
    .access_en        (access_en),
    .pwr_on           (pwr_on),
    .busy             (busy),
    .timeout_err      (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Chain ack follows pwr_enable_b three cycles late, or is forced stuck high.
  always @(posedge clk) begin
    if (rst) ack_sh <= 3'b111;
    else     ack_sh <= {ack_sh[1:0], pwr_enable_b};
  end
  assign pwr_enable_b_ack = ack_stuck | ack_sh[2];

  assign obs = {pwr_enable_b, pgcb_isol_en, ip_reset_b, access_en, pwr_on, busy, timeout_err};

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Safety invariants sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst && access_en === 1'b1)
      check_eq("inv_access", 32'({pgcb_isol_en, ip_reset_b, pwr_enable_b}), 32'(3'b010));
    if (!rst && pgcb_isol_en === 1'b0)
      check_eq("inv_isol", 32'(pwr_enable_b), 32'(1'b0));
  end

  initial begin
    n_vec      = 0;
    n_err      = 0;
    rst        = 1'b1;
    pwr_req    = 1'b0;
    mem_active = 1'b0;
    err_clr    = 1'b0;
    ack_stuck  = 1'b0;
    iso_seen   = 1'b0;

    tick(2);
    check_eq("reset", 32'(obs), 32'(O_OFF));
    rst = 1'b0;

    // Power-up with ack three cycles after pwr_enable_b falls
    pwr_req = 1'b1;
    tick(1);  check_eq("pu_up_wait", 32'(obs), 32'(O_UP_WAIT));
    tick(3);  check_eq("pu_up_hold", 32'(obs), 32'(O_UP_WAIT));
    tick(1);  check_eq("pu_iso_rel", 32'(obs), 32'(O_ISO_REL));
    tick(3);  check_eq("pu_iso_hold", 32'(obs), 32'(O_ISO_REL));
    tick(1);  check_eq("pu_rst_rel", 32'(obs), 32'(O_RST_REL));
    tick(7);  check_eq("pu_rst_hold", 32'(obs), 32'(O_RST_REL));
    tick(1);  check_eq("pu_on", 32'(obs), 32'(O_ON));

    // Power-down with mem_active held for 10 cycles
    mem_active = 1'b1;
    pwr_req    = 1'b0;
    tick(1);  check_eq("pd_quiesce", 32'(obs), 32'(O_QUIESCE));
    tick(9);  check_eq("pd_quiesce_hold", 32'(obs), 32'(O_QUIESCE));
    mem_active = 1'b0;
    tick(1);  check_eq("pd_iso_set", 32'(obs), 32'(O_ISO_SET));
    tick(3);  check_eq("pd_iso_hold", 32'(obs), 32'(O_ISO_SET));
    tick(1);  check_eq("pd_dn_wait", 32'(obs), 32'(O_DN_WAIT));
    tick(3);  check_eq("pd_dn_hold", 32'(obs), 32'(O_DN_WAIT));
    tick(1);  check_eq("pd_off", 32'(obs), 32'(O_OFF));

    // Ack stuck high: power-up timeout after 255 cycles
    ack_stuck = 1'b1;
    pwr_req   = 1'b1;
    tick(1);  check_eq("to_up_wait", 32'(obs), 32'(O_UP_WAIT));
    pwr_req = 1'b0;
    for (int i = 0; i < 254; i++) begin
      tick(1);
      if (pgcb_isol_en !== 1'b1) iso_seen = 1'b1;
    end
    check_eq("to_up_hold254", 32'(obs), 32'(O_UP_WAIT));
    check_eq("to_isol_kept", 32'(iso_seen), 32'(1'b0));
    tick(1);  check_eq("to_dn_wait_err", 32'(obs), 32'(O_DN_WAIT | 7'b0000001));
    tick(1);  check_eq("to_off_err", 32'(obs), 32'(O_OFF | 7'b0000001));
    err_clr = 1'b1;
    tick(1);  err_clr = 1'b0;
    check_eq("to_err_clr", 32'(obs), 32'(O_OFF));

    // Clear arriving on the same edge as a new timeout loses
    pwr_req = 1'b1;
    tick(1);  pwr_req = 1'b0;
    tick(254);
    err_clr = 1'b1;
    tick(1);  err_clr = 1'b0;
    check_eq("to_set_over_clr", 32'(obs), 32'(O_DN_WAIT | 7'b0000001));
    tick(1);  check_eq("to_off_err2", 32'(obs), 32'(O_OFF | 7'b0000001));
    ack_stuck = 1'b0;
    err_clr   = 1'b1;
    tick(1);  err_clr = 1'b0;
    check_eq("to_err_clr2", 32'(obs), 32'(O_OFF));

    // pwr_req drops during RST_REL: sequence still completes to ON
    pwr_req = 1'b1;
    tick(1);  check_eq("tg_up_wait", 32'(obs), 32'(O_UP_WAIT));
    tick(8);  check_eq("tg_rst_rel", 32'(obs), 32'(O_RST_REL));
    pwr_req = 1'b0;
    tick(7);  check_eq("tg_rst_hold", 32'(obs), 32'(O_RST_REL));
    tick(1);  check_eq("tg_on", 32'(obs), 32'(O_ON));
    tick(1);  check_eq("tg_quiesce", 32'(obs), 32'(O_QUIESCE));
    tick(1);  check_eq("tg_iso_set", 32'(obs), 32'(O_ISO_SET));
    tick(4);  check_eq("tg_dn_wait", 32'(obs), 32'(O_DN_WAIT));
    tick(4);  check_eq("tg_off", 32'(obs), 32'(O_OFF));

    // Reset in ON
    pwr_req = 1'b1;
    tick(17); check_eq("rs_on", 32'(obs), 32'(O_ON));
    rst     = 1'b1;
    pwr_req = 1'b0;
    tick(1);  check_eq("rs_from_on", 32'(obs), 32'(O_OFF));
    rst = 1'b0;
    tick(1);  check_eq("rs_on_stay_off", 32'(obs), 32'(O_OFF));

    // Reset in ISO_REL
    pwr_req = 1'b1;
    tick(1);  check_eq("rs_up_wait", 32'(obs), 32'(O_UP_WAIT));
    tick(4);  check_eq("rs_iso_rel", 32'(obs), 32'(O_ISO_REL));
    rst     = 1'b1;
    pwr_req = 1'b0;
    tick(1);  check_eq("rs_from_iso_rel", 32'(obs), 32'(O_OFF));
    rst = 1'b0;
    tick(1);  check_eq("rs_iso_stay_off", 32'(obs), 32'(O_OFF));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
